// File: rtl/execute_pkg.sv
// Shared definitions for the EX stage: ALU opcode encodings, default word size,
// mult/div FSM state and operation types, and opcode classification helpers.
//
// Build option: EXECUTE_DIV_EN -- when defined, DIV/DIVU issue to the iterative
// unit; when undefined they decode as no-ops that never stall.
package execute_pkg;

  localparam int WORD_SIZE_DEF = 32;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_LUI   = 5'd11;
  localparam logic [4:0] ALU_MFHI  = 5'd12;
  localparam logic [4:0] ALU_MFLO  = 5'd13;
  localparam logic [4:0] ALU_MULT  = 5'd14;
  localparam logic [4:0] ALU_MULTU = 5'd15;
  localparam logic [4:0] ALU_DIV   = 5'd16;
  localparam logic [4:0] ALU_DIVU  = 5'd17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Ops that never write the register file (HI/LO producers), enabled or not.
  function automatic logic is_hilo_write(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
  endfunction

  // Ops that actually launch the iterative unit in this build.
  function automatic logic is_md_start_op(input logic [4:0] op);
`ifdef EXECUTE_DIV_EN
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
`else
    return (op == ALU_MULT) || (op == ALU_MULTU);
`endif
  endfunction

  // Ops that must wait while a HI/LO result is pending.
  function automatic logic needs_hilo(input logic [4:0] op);
    return (op == ALU_MFHI) || (op == ALU_MFLO) || is_md_start_op(op);
  endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative HI/LO multiply/divide unit.
//   clk, rst   : clock, synchronous active-high reset (aborts, clears HI/LO)
//   start_i    : launch op_i on a_i/b_i (only honoured in IDLE)
//   op_i       : MULT / MULTU / DIV / DIVU
//   busy_o     : high in RUN and DONE
//   hi_o, lo_o : architectural HI/LO registers
//   state_o    : FSM state, for debug observation
// Works on magnitudes: shift-add multiply or restoring divide for CYC
// iterations, then a DONE cycle applies signs and writes HI/LO.
// Divider datapath exists only when EXECUTE_DIV_EN is defined.
import execute_pkg::*;

module execute_muldiv #(
  parameter int W   = 32,
  parameter int CYC = 32  // must equal W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  md_op_e       op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output md_state_e    state_o
);

  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

  md_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Working register: multiply = {partial product, multiplier};
  // divide = {partial remainder, dividend/quotient}.
  logic [2*W-1:0] p_q, p_d;
  logic [W-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic           is_div_q, is_div_d;
  logic           qneg_q, qneg_d;    // product / quotient negative
  logic           rneg_q, rneg_d;    // remainder negative (dividend sign)
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           sgn_op;
  logic           sa, sb;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] prod_fix;
`ifdef EXECUTE_DIV_EN
  logic [W:0]     rem_sh;
  logic [W:0]     rem_diff;
  logic [2*W-1:0] div_next;
`endif

  always_comb begin
    sgn_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    sa     = sgn_op && a_i[W-1];
    sb     = sgn_op && b_i[W-1];
    mag_a  = sa ? (~a_i + 1'b1) : a_i;
    mag_b  = sb ? (~b_i + 1'b1) : b_i;

    // One shift-add step: conditionally add, then shift the whole pair right.
    mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, p_q[W-1:1]};
    prod_fix = qneg_q ? (~p_q + 1'b1) : p_q;

`ifdef EXECUTE_DIV_EN
    // One restoring step: shift in the next dividend bit, keep the
    // difference if it does not borrow. Divisor 0 never borrows, giving
    // an all-ones quotient and the dividend as remainder.
    rem_sh   = p_q[2*W-1:W-1];
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (!rem_diff[W])
      div_next = {rem_diff[W-1:0], p_q[W-2:0], 1'b1};
    else
      div_next = {rem_sh[W-1:0], p_q[W-2:0], 1'b0};
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          p_d      = {{W{1'b0}}, mag_a};
          mcand_d  = mag_b;
          is_div_d = (op_i == MD_DIV) || (op_i == MD_DIVU);
          qneg_d   = sa ^ sb;
          rneg_d   = sa;
          cnt_d    = CW'(CYC - 1);
          state_d  = MD_RUN;
        end
      end
      MD_RUN: begin
`ifdef EXECUTE_DIV_EN
        p_d = is_div_q ? div_next : mul_next;
`else
        p_d = mul_next;
`endif
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      MD_DONE: begin
        if (is_div_q) begin
          lo_d = qneg_q ? (~p_q[W-1:0] + 1'b1) : p_q[W-1:0];
          hi_d = rneg_q ? (~p_q[2*W-1:W] + 1'b1) : p_q[2*W-1:W];
        end else begin
          lo_d = prod_fix[W-1:0];
          hi_d = prod_fix[2*W-1:W];
        end
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o  = (state_q != MD_IDLE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: rtl/execute.sv
// EX stage of the 5-stage MIPS pipeline: ALU, HI/LO mult/div unit and the
// EX/MEM pipeline registers.
//   Inputs  : clk, rst (sync, active-high), ID/EX operands rs/rt/imm/shamt,
//             alu_src, alu_op, rd_en, rd_addr, rd_data_sel, mem_en
//   Outputs : stall_ex (ID/EX must hold), md_busy, md_state_dbg (mult/div
//             FSM state), registered EX/MEM alu_data, rt_data, rd_en,
//             rd_addr, rd_data_sel, mem_en
// Handshake: stall_ex is combinational; while high the presented ID/EX
// inputs are ignored and a bubble is registered, so upstream must hold
// them until a cycle where stall_ex is low.
// Build option: EXECUTE_DIV_EN enables DIV/DIVU; otherwise they are no-ops.
import execute_pkg::*;

module execute #(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MD_CYCLES = WORD_SIZE_DEF  // must equal WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] rs_data_id_ex,
  input  logic [WORD_SIZE-1:0] rt_data_id_ex,
  input  logic [WORD_SIZE-1:0] imm_id_ex,
  input  logic [4:0]           shamt_id_ex,
  input  logic                 alu_src_id_ex,
  input  logic [4:0]           alu_op_id_ex,
  input  logic                 rd_en_id_ex,
  input  logic [4:0]           rd_addr_id_ex,
  input  logic                 rd_data_sel_id_ex,
  input  logic                 mem_en_id_ex,
  output logic                 stall_ex,
  output logic                 md_busy,
  output md_state_e            md_state_dbg,
  output logic [WORD_SIZE-1:0] alu_data_ex_mem,
  output logic [WORD_SIZE-1:0] rt_data_ex_mem,
  output logic                 rd_en_ex_mem,
  output logic [4:0]           rd_addr_ex_mem,
  output logic                 rd_data_sel_ex_mem,
  output logic                 mem_en_ex_mem
);

  localparam int W = WORD_SIZE;

  logic [W-1:0] op_b;
  logic [W-1:0] alu_res;
  logic [W-1:0] hi, lo;
  logic         md_start;
  md_op_e       md_op;

  logic [W-1:0] alu_q, alu_d;
  logic [W-1:0] rt_q, rt_d;
  logic         rd_en_q, rd_en_d;
  logic [4:0]   rd_addr_q, rd_addr_d;
  logic         sel_q, sel_d;
  logic         mem_en_q, mem_en_d;

  execute_muldiv #(
    .W   (W),
    .CYC (MD_CYCLES)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (rs_data_id_ex),
    .b_i     (rt_data_id_ex),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo),
    .state_o (md_state_dbg)
  );

  // Only ops touching HI/LO wait for the unit; everything else overlaps it.
  assign stall_ex = md_busy && needs_hilo(alu_op_id_ex);
  assign md_start = !stall_ex && is_md_start_op(alu_op_id_ex);

  always_comb begin
    case (alu_op_id_ex)
      ALU_MULTU: md_op = MD_MULTU;
      ALU_DIV:   md_op = MD_DIV;
      ALU_DIVU:  md_op = MD_DIVU;
      default:   md_op = MD_MULT;
    endcase
  end

  always_comb begin
    op_b    = alu_src_id_ex ? imm_id_ex : rt_data_id_ex;
    alu_res = '0;
    case (alu_op_id_ex)
      ALU_ADD:  alu_res = rs_data_id_ex + op_b;
      ALU_SUB:  alu_res = rs_data_id_ex - op_b;
      ALU_AND:  alu_res = rs_data_id_ex & op_b;
      ALU_OR:   alu_res = rs_data_id_ex | op_b;
      ALU_XOR:  alu_res = rs_data_id_ex ^ op_b;
      ALU_NOR:  alu_res = ~(rs_data_id_ex | op_b);
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(rs_data_id_ex) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (rs_data_id_ex < op_b)};
      // Shifts act on the B operand (rt), as in MIPS sll/srl/sra.
      ALU_SLL:  alu_res = op_b << shamt_id_ex;
      ALU_SRL:  alu_res = op_b >> shamt_id_ex;
      ALU_SRA:  alu_res = W'($signed(op_b) >>> shamt_id_ex);
      ALU_LUI:  alu_res = imm_id_ex << 16;
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    alu_d     = alu_res;
    rt_d      = rt_data_id_ex;
    rd_en_d   = rd_en_id_ex;
    rd_addr_d = rd_addr_id_ex;
    sel_d     = rd_data_sel_id_ex;
    mem_en_d  = mem_en_id_ex;
    if (stall_ex) begin
      alu_d     = '0;
      rt_d      = '0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      sel_d     = 1'b0;
      mem_en_d  = 1'b0;
    end else if (is_hilo_write(alu_op_id_ex)) begin
      // Issue slot of a HI/LO producer travels down as a harmless no-op.
      alu_d    = '0;
      rd_en_d  = 1'b0;
      mem_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q     <= '0;
      rt_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      sel_q     <= 1'b0;
      mem_en_q  <= 1'b0;
    end else begin
      alu_q     <= alu_d;
      rt_q      <= rt_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      sel_q     <= sel_d;
      mem_en_q  <= mem_en_d;
    end
  end

  assign alu_data_ex_mem    = alu_q;
  assign rt_data_ex_mem     = rt_q;
  assign rd_en_ex_mem       = rd_en_q;
  assign rd_addr_ex_mem     = rd_addr_q;
  assign rd_data_sel_ex_mem = sel_q;
  assign mem_en_ex_mem      = mem_en_q;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage: reset, ALU ops, MULT with stalled MFLO/MFHI,
// DIV/DIVU (or their no-op behaviour), reset mid-multiply, store during busy.
import execute_pkg::*;

module tb_execute;

  logic        clk;
  logic        rst;
  logic [31:0] rs_data_id_ex, rt_data_id_ex, imm_id_ex;
  logic [4:0]  shamt_id_ex;
  logic        alu_src_id_ex;
  logic [4:0]  alu_op_id_ex;
  logic        rd_en_id_ex;
  logic [4:0]  rd_addr_id_ex;
  logic        rd_data_sel_id_ex;
  logic        mem_en_id_ex;
  logic        stall_ex, md_busy;
  md_state_e   md_state_dbg;
  logic [31:0] alu_data_ex_mem, rt_data_ex_mem;
  logic        rd_en_ex_mem;
  logic [4:0]  rd_addr_ex_mem;
  logic        rd_data_sel_ex_mem, mem_en_ex_mem;

  int checks = 0;
  int errors = 0;

  execute #(.WORD_SIZE(32), .MD_CYCLES(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .rs_data_id_ex      (rs_data_id_ex),
    .rt_data_id_ex      (rt_data_id_ex),
    .imm_id_ex          (imm_id_ex),
    .shamt_id_ex        (shamt_id_ex),
    .alu_src_id_ex      (alu_src_id_ex),
    .alu_op_id_ex       (alu_op_id_ex),
    .rd_en_id_ex        (rd_en_id_ex),
    .rd_addr_id_ex      (rd_addr_id_ex),
    .rd_data_sel_id_ex  (rd_data_sel_id_ex),
    .mem_en_id_ex       (mem_en_id_ex),
    .stall_ex           (stall_ex),
    .md_busy            (md_busy),
    .md_state_dbg       (md_state_dbg),
    .alu_data_ex_mem    (alu_data_ex_mem),
    .rt_data_ex_mem     (rt_data_ex_mem),
    .rd_en_ex_mem       (rd_en_ex_mem),
    .rd_addr_ex_mem     (rd_addr_ex_mem),
    .rd_data_sel_ex_mem (rd_data_sel_ex_mem),
    .mem_en_ex_mem      (mem_en_ex_mem)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] sh, input logic src,
                       input logic rden, input logic [4:0] rda, input logic sel,
                       input logic men);
    alu_op_id_ex      = op;
    rs_data_id_ex     = rs;
    rt_data_id_ex     = rt;
    imm_id_ex         = imm;
    shamt_id_ex       = sh;
    alu_src_id_ex     = src;
    rd_en_id_ex       = rden;
    rd_addr_id_ex     = rda;
    rd_data_sel_id_ex = sel;
    mem_en_id_ex      = men;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop;
    drive(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    drive(ALU_ADD, 32'h11, 32'h22, 32'h33, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1);
    step();
    step();
    checks++;
    if (alu_data_ex_mem !== 32'h0) begin
      errors++; $display("FAIL reset_alu got=%h exp=%h", alu_data_ex_mem, 32'h0);
    end
    checks++;
    if ({rd_en_ex_mem, mem_en_ex_mem, rd_data_sel_ex_mem, rd_addr_ex_mem} !== 8'h00) begin
      errors++; $display("FAIL reset_ctl got=%b%b%b%h exp=0", rd_en_ex_mem, mem_en_ex_mem,
                         rd_data_sel_ex_mem, rd_addr_ex_mem);
    end
    checks++;
    if (rt_data_ex_mem !== 32'h0) begin
      errors++; $display("FAIL reset_rt got=%h exp=0", rt_data_ex_mem);
    end
    checks++;
    if (md_busy !== 1'b0 || md_state_dbg !== MD_IDLE) begin
      errors++; $display("FAIL reset_md busy=%b state=%0d exp busy=0 state=0", md_busy, md_state_dbg);
    end
    rst = 1'b0;
    drive_nop();
    step();
  endtask

  task automatic test_alu;
    logic [4:0]  t_op  [14];
    logic [31:0] t_rs  [14];
    logic [31:0] t_rt  [14];
    logic [31:0] t_imm [14];
    logic [4:0]  t_sh  [14];
    logic        t_src [14];
    logic [31:0] t_exp [14];
    t_op[0]  = ALU_ADD;  t_rs[0]  = 32'h7fffffff; t_rt[0]  = 32'h1;        t_imm[0]  = 0; t_sh[0]  = 0;  t_src[0]  = 0; t_exp[0]  = 32'h80000000;
    t_op[1]  = ALU_SUB;  t_rs[1]  = 32'h5;        t_rt[1]  = 32'h7;        t_imm[1]  = 0; t_sh[1]  = 0;  t_src[1]  = 0; t_exp[1]  = 32'hfffffffe;
    t_op[2]  = ALU_AND;  t_rs[2]  = 32'hf0f0ff00; t_rt[2]  = 32'h0ff00ff0; t_imm[2]  = 0; t_sh[2]  = 0;  t_src[2]  = 0; t_exp[2]  = 32'h00f00f00;
    t_op[3]  = ALU_OR;   t_rs[3]  = 32'hf0f0ff00; t_rt[3]  = 32'h0ff00ff0; t_imm[3]  = 0; t_sh[3]  = 0;  t_src[3]  = 0; t_exp[3]  = 32'hfff0fff0;
    t_op[4]  = ALU_XOR;  t_rs[4]  = 32'hf0f0ff00; t_rt[4]  = 32'h0ff00ff0; t_imm[4]  = 0; t_sh[4]  = 0;  t_src[4]  = 0; t_exp[4]  = 32'hff00f0f0;
    t_op[5]  = ALU_NOR;  t_rs[5]  = 32'hf0f0ff00; t_rt[5]  = 32'h0ff00ff0; t_imm[5]  = 0; t_sh[5]  = 0;  t_src[5]  = 0; t_exp[5]  = 32'h000f000f;
    t_op[6]  = ALU_SLT;  t_rs[6]  = 32'hffffffff; t_rt[6]  = 32'h1;        t_imm[6]  = 0; t_sh[6]  = 0;  t_src[6]  = 0; t_exp[6]  = 32'h1;
    t_op[7]  = ALU_SLTU; t_rs[7]  = 32'hffffffff; t_rt[7]  = 32'h1;        t_imm[7]  = 0; t_sh[7]  = 0;  t_src[7]  = 0; t_exp[7]  = 32'h0;
    t_op[8]  = ALU_SRA;  t_rs[8]  = 32'h80000000; t_rt[8]  = 32'h80000000; t_imm[8]  = 0; t_sh[8]  = 4;  t_src[8]  = 0; t_exp[8]  = 32'hf8000000;
    t_op[9]  = ALU_SRL;  t_rs[9]  = 32'h80000000; t_rt[9]  = 32'h80000000; t_imm[9]  = 0; t_sh[9]  = 4;  t_src[9]  = 0; t_exp[9]  = 32'h08000000;
    t_op[10] = ALU_SLL;  t_rs[10] = 32'h1;        t_rt[10] = 32'h1;        t_imm[10] = 0; t_sh[10] = 31; t_src[10] = 0; t_exp[10] = 32'h80000000;
    t_op[11] = ALU_LUI;  t_rs[11] = 32'h0;        t_rt[11] = 32'h0;        t_imm[11] = 32'h1234; t_sh[11] = 0; t_src[11] = 1; t_exp[11] = 32'h12340000;
    t_op[12] = ALU_ADD;  t_rs[12] = 32'h1000;     t_rt[12] = 32'h5;        t_imm[12] = 32'hffffffff; t_sh[12] = 0; t_src[12] = 1; t_exp[12] = 32'h00000fff;
    t_op[13] = 5'd31;    t_rs[13] = 32'h1234;     t_rt[13] = 32'h5678;     t_imm[13] = 32'h9; t_sh[13] = 1; t_src[13] = 0; t_exp[13] = 32'h0;
    for (int i = 0; i < 14; i++) begin
      drive(t_op[i], t_rs[i], t_rt[i], t_imm[i], t_sh[i], t_src[i], 1'b1, 5'(i + 1),
            1'(i % 2), 1'b0);
      step();
      checks++;
      if (alu_data_ex_mem !== t_exp[i]) begin
        errors++; $display("FAIL alu_%0d op=%0d got=%h exp=%h", i, t_op[i], alu_data_ex_mem, t_exp[i]);
      end
      checks++;
      if (rd_en_ex_mem !== 1'b1 || rd_addr_ex_mem !== 5'(i + 1) || rd_data_sel_ex_mem !== 1'(i % 2)) begin
        errors++; $display("FAIL alu_ctl_%0d got en=%b addr=%0d sel=%b exp en=1 addr=%0d sel=%0d",
                           i, rd_en_ex_mem, rd_addr_ex_mem, rd_data_sel_ex_mem, i + 1, i % 2);
      end
      checks++;
      if (rt_data_ex_mem !== t_rt[i]) begin
        errors++; $display("FAIL alu_rt_%0d got=%h exp=%h", i, rt_data_ex_mem, t_rt[i]);
      end
    end
    drive_nop();
    step();
  endtask

  task automatic test_mult_stall;
    int n;
    drive(ALU_MULT, 32'hfffffffd, 32'h5, 32'h0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    step();
    checks++;
    if (rd_en_ex_mem !== 1'b0 || md_busy !== 1'b1 || md_state_dbg !== MD_RUN) begin
      errors++; $display("FAIL mult_issue rd_en=%b busy=%b state=%0d exp 0 1 1", rd_en_ex_mem, md_busy, md_state_dbg);
    end
    drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    #1;
    n = 0;
    while (stall_ex === 1'b1 && n < 100) begin
      step();
      n++;
      checks++;
      if (rd_en_ex_mem !== 1'b0 || alu_data_ex_mem !== 32'h0 || mem_en_ex_mem !== 1'b0) begin
        errors++; $display("FAIL mult_bubble cyc=%0d rd_en=%b alu=%h mem_en=%b exp 0", n, rd_en_ex_mem,
                           alu_data_ex_mem, mem_en_ex_mem);
      end
    end
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL mult_stall_len got=%0d exp=33", n);
    end
    step();
    checks++;
    if (alu_data_ex_mem !== 32'hfffffff1 || rd_en_ex_mem !== 1'b1 || rd_addr_ex_mem !== 5'd3) begin
      errors++; $display("FAIL mult_mflo got=%h en=%b addr=%0d exp=fffffff1 1 3", alu_data_ex_mem,
                         rd_en_ex_mem, rd_addr_ex_mem);
    end
    drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_data_ex_mem !== 32'hffffffff) begin
      errors++; $display("FAIL mult_mfhi got=%h exp=ffffffff", alu_data_ex_mem);
    end
    drive_nop();
    step();
  endtask

`ifdef EXECUTE_DIV_EN
  task automatic test_div;
    logic [4:0]  d_op  [2];
    logic [31:0] d_a   [2];
    logic [31:0] d_b   [2];
    logic [31:0] d_lo  [2];
    logic [31:0] d_hi  [2];
    int n;
    d_op[0] = ALU_DIV;  d_a[0] = 32'hfffffff9; d_b[0] = 32'h2; d_lo[0] = 32'hfffffffd; d_hi[0] = 32'hffffffff;
    d_op[1] = ALU_DIVU; d_a[1] = 32'h7;        d_b[1] = 32'h0; d_lo[1] = 32'hffffffff; d_hi[1] = 32'h7;
    for (int i = 0; i < 2; i++) begin
      drive(d_op[i], d_a[i], d_b[i], 32'h0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      step();
      drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      #1;
      n = 0;
      while (stall_ex === 1'b1 && n < 100) begin
        step();
        n++;
      end
      checks++;
      if (n != 33) begin
        errors++; $display("FAIL div_stall_len_%0d got=%0d exp=33", i, n);
      end
      step();
      checks++;
      if (alu_data_ex_mem !== d_lo[i]) begin
        errors++; $display("FAIL div_lo_%0d got=%h exp=%h", i, alu_data_ex_mem, d_lo[i]);
      end
      drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      step();
      checks++;
      if (alu_data_ex_mem !== d_hi[i]) begin
        errors++; $display("FAIL div_hi_%0d got=%h exp=%h", i, alu_data_ex_mem, d_hi[i]);
      end
    end
    drive_nop();
    step();
  endtask
`else
  // Without the divider, DIV is a no-op: no busy, HI/LO keep the MULT result.
  task automatic test_div;
    drive(ALU_DIV, 32'hfffffff9, 32'h2, 32'h0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin
      errors++; $display("FAIL nodiv_stall got=%b exp=0", stall_ex);
    end
    step();
    checks++;
    if (md_busy !== 1'b0 || rd_en_ex_mem !== 1'b0) begin
      errors++; $display("FAIL nodiv_busy busy=%b rd_en=%b exp 0 0", md_busy, rd_en_ex_mem);
    end
    drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_data_ex_mem !== 32'hfffffff1) begin
      errors++; $display("FAIL nodiv_lo got=%h exp=fffffff1", alu_data_ex_mem);
    end
    drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_data_ex_mem !== 32'hffffffff) begin
      errors++; $display("FAIL nodiv_hi got=%h exp=ffffffff", alu_data_ex_mem);
    end
    drive_nop();
    step();
  endtask
`endif

  task automatic test_reset_mid_mult;
    drive(ALU_MULT, 32'h3, 32'h5, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    drive_nop();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    drive(ALU_ADD, 32'h10, 32'h20, 32'h0, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1);
    step();
    checks++;
    if (md_busy !== 1'b0 || md_state_dbg !== MD_IDLE) begin
      errors++; $display("FAIL rstmid_busy busy=%b state=%0d exp 0 0", md_busy, md_state_dbg);
    end
    checks++;
    if (alu_data_ex_mem !== 32'h0 || rt_data_ex_mem !== 32'h0 || rd_en_ex_mem !== 1'b0 ||
        mem_en_ex_mem !== 1'b0 || rd_addr_ex_mem !== 5'd0 || rd_data_sel_ex_mem !== 1'b0) begin
      errors++; $display("FAIL rstmid_out alu=%h rt=%h en=%b mem=%b exp all 0", alu_data_ex_mem,
                         rt_data_ex_mem, rd_en_ex_mem, mem_en_ex_mem);
    end
    rst = 1'b0;
    drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_data_ex_mem !== 32'h0) begin
      errors++; $display("FAIL rstmid_mfhi got=%h exp=0", alu_data_ex_mem);
    end
    drive_nop();
    for (int i = 0; i < 40; i++) step();
    drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_data_ex_mem !== 32'h0) begin
      errors++; $display("FAIL rstmid_mflo got=%h exp=0", alu_data_ex_mem);
    end
    drive_nop();
    step();
  endtask

  task automatic test_store_during_busy;
    int n;
    drive(ALU_MULTU, 32'h2, 32'h3, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    drive(ALU_ADD, 32'h1000, 32'hdeadbeef, 32'hffffffff, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin
      errors++; $display("FAIL sw_stall got=%b exp=0", stall_ex);
    end
    step();
    checks++;
    if (alu_data_ex_mem !== 32'h00000fff || rt_data_ex_mem !== 32'hdeadbeef ||
        mem_en_ex_mem !== 1'b1 || rd_en_ex_mem !== 1'b0) begin
      errors++; $display("FAIL sw_out addr=%h data=%h mem=%b en=%b exp=00000fff deadbeef 1 0",
                         alu_data_ex_mem, rt_data_ex_mem, mem_en_ex_mem, rd_en_ex_mem);
    end
    checks++;
    if (md_busy !== 1'b1) begin
      errors++; $display("FAIL sw_busy got=%b exp=1", md_busy);
    end
    // Back-to-back ALU op still overlaps the multiply.
    drive(ALU_XOR, 32'h0000ffff, 32'h00ff00ff, 32'h0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_data_ex_mem !== 32'h00ffff00 || rd_en_ex_mem !== 1'b1 || rd_addr_ex_mem !== 5'd12) begin
      errors++; $display("FAIL b2b_xor got=%h en=%b addr=%0d exp=00ffff00 1 12", alu_data_ex_mem,
                         rd_en_ex_mem, rd_addr_ex_mem);
    end
    drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0);
    #1;
    n = 0;
    while (stall_ex === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL sw_wait timeout cycles=%0d limit=100", n);
    end
    step();
    checks++;
    if (alu_data_ex_mem !== 32'h6) begin
      errors++; $display("FAIL multu_lo got=%h exp=00000006", alu_data_ex_mem);
    end
    drive_nop();
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    drive_nop();
    test_reset();
    test_alu();
    test_mult_stall();
    test_div();
    test_reset_mid_mult();
    test_store_during_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
